// File: rtl/rgb2gray_stream_if.sv
// Pixel stream bundle between the RGB source, the luma converter and the Sobel window logic.
// The master side feeds RGB pixels and consumes tagged gray pixels; the slave side is the converter.
interface rgb2gray_stream_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 9
);
    logic             frame_start;
    logic             rgb_enable;
    logic [23:0]      rgb_data_in;
    logic             gray_valid;
    logic [7:0]       gray_data;
    logic [COL_W-1:0] gray_col;
    logic [ROW_W-1:0] gray_row;
    logic             gray_sol;
    logic             gray_eol;
    logic             gray_eof;

    modport master (
        output frame_start, rgb_enable, rgb_data_in,
        input  gray_valid, gray_data, gray_col, gray_row, gray_sol, gray_eol, gray_eof
    );

    modport slave (
        input  frame_start, rgb_enable, rgb_data_in,
        output gray_valid, gray_data, gray_col, gray_row, gray_sol, gray_eol, gray_eof
    );
endinterface

// File: rtl/rgb2gray_stream.sv
// RGB888 to 8-bit luma converter with a 3-stage pipeline; every output pixel carries its
// raster position and line/frame markers so downstream window logic stays aligned.
module rgb2gray_stream #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input logic clk,
    input logic rst_p,
    rgb2gray_stream_if.slave bus
);

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-1:0] tag_col;
    logic [ROW_W-1:0] tag_row;
    logic             tag_last_col;
    logic             tag_last_row;

    logic             s1_valid;
    logic [15:0]      s1_prod_r;
    logic [15:0]      s1_prod_g;
    logic [15:0]      s1_prod_b;
    logic [COL_W-1:0] s1_col;
    logic [ROW_W-1:0] s1_row;

    logic             s2_valid;
    logic [17:0]      s2_sum;
    logic [COL_W-1:0] s2_col;
    logic [ROW_W-1:0] s2_row;
    logic [9:0]       s2_shift;
    logic [7:0]       s2_luma;

    // A frame_start coinciding with a pixel re-tags that very pixel as the frame origin.
    always_comb begin
        tag_col      = bus.frame_start ? '0 : col_cnt;
        tag_row      = bus.frame_start ? '0 : row_cnt;
        tag_last_col = (tag_col == COL_W'(IMG_WIDTH - 1));
        tag_last_row = (tag_row == ROW_W'(IMG_HEIGHT - 1));
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.rgb_enable) begin
            if (tag_last_col) begin
                col_cnt <= '0;
                row_cnt <= tag_last_row ? '0 : tag_row + ROW_W'(1);
            end else begin
                col_cnt <= tag_col + COL_W'(1);
                row_cnt <= tag_row;
            end
        end else if (bus.frame_start) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            s1_valid  <= 1'b0;
            s1_prod_r <= '0;
            s1_prod_g <= '0;
            s1_prod_b <= '0;
            s1_col    <= '0;
            s1_row    <= '0;
        end else begin
            s1_valid <= bus.rgb_enable;
            if (bus.rgb_enable) begin
                s1_prod_r <= 16'(bus.rgb_data_in[23:16]) * 16'd77;
                s1_prod_g <= 16'(bus.rgb_data_in[15:8])  * 16'd150;
                s1_prod_b <= 16'(bus.rgb_data_in[7:0])   * 16'd29;
                s1_col    <= tag_col;
                s1_row    <= tag_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_col   <= '0;
            s2_row   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum <= 18'(s1_prod_r) + 18'(s1_prod_g) + 18'(s1_prod_b) + 18'd128;
                s2_col <= s1_col;
                s2_row <= s1_row;
            end
        end
    end

    // The weights sum to 256 so overflow cannot occur with 8-bit inputs; the clamp is a guard.
    always_comb begin
        s2_shift = 10'(s2_sum >> 8);
        s2_luma  = (|s2_shift[9:8]) ? 8'hFF : s2_shift[7:0];
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            bus.gray_valid <= 1'b0;
            bus.gray_data  <= '0;
            bus.gray_col   <= '0;
            bus.gray_row   <= '0;
            bus.gray_sol   <= 1'b0;
            bus.gray_eol   <= 1'b0;
            bus.gray_eof   <= 1'b0;
        end else begin
            bus.gray_valid <= s2_valid;
            bus.gray_sol   <= s2_valid && (s2_col == '0);
            bus.gray_eol   <= s2_valid && (s2_col == COL_W'(IMG_WIDTH - 1));
            bus.gray_eof   <= s2_valid && (s2_col == COL_W'(IMG_WIDTH - 1))
                                       && (s2_row == ROW_W'(IMG_HEIGHT - 1));
            if (s2_valid) begin
                bus.gray_data <= s2_luma;
                bus.gray_col  <= s2_col;
                bus.gray_row  <= s2_row;
            end
        end
    end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed bench for rgb2gray_stream on a tiny 4x2 raster; a scoreboard queue holds the
// expected tagged gray pixel for every accepted RGB pixel.
module tb_rgb2gray_stream;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 3;
    localparam int RW = 2;

    typedef struct packed {
        logic [7:0]    data;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          sol;
        logic          eol;
        logic          eof;
    } px_t;

    logic clk   = 1'b0;
    logic rst_p = 1'b0;

    rgb2gray_stream_if #(.COL_W(CW), .ROW_W(RW)) bus ();

    rgb2gray_stream #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (CW),
        .ROW_W     (RW)
    ) dut (
        .clk  (clk),
        .rst_p(rst_p),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    px_t      sb[$];
    px_t      last_out = '0;
    int       n_checks = 0;
    int       n_fail   = 0;
    int       col_m    = 0;
    int       row_m    = 0;
    logic [2:0] exp_v  = '0;
    bit       mon_en   = 1'b0;

    function automatic logic [7:0] luma(input logic [23:0] rgb);
        int y;
        y = (77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]) + 128) >> 8;
        if (y > 255) y = 255;
        return 8'(y);
    endfunction

    // Reference valid pipe: accepted pixels surface after three rising edges, reset flushes it.
    always @(posedge clk or posedge rst_p) begin
        if (rst_p) exp_v <= '0;
        else       exp_v <= {exp_v[1:0], bus.rgb_enable};
    end

    always @(negedge clk) begin
        px_t got;
        px_t want;
        if (mon_en) begin
            got = {bus.gray_data, bus.gray_col, bus.gray_row, bus.gray_sol, bus.gray_eol, bus.gray_eof};
            n_checks++;
            assert (bus.gray_valid === exp_v[2]) else begin
                n_fail++;
                $error("FAIL gray_valid: observed %b expected %b", bus.gray_valid, exp_v[2]);
            end
            if (bus.gray_valid === 1'b1) begin
                n_checks++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_pixel: observed %h expected none", got);
                end
                if (sb.size() > 0) begin
                    want = sb.pop_front();
                    n_checks++;
                    assert (got === want) else begin
                        n_fail++;
                        $error("FAIL pixel: observed %h expected %h", got, want);
                    end
                    last_out = want;
                end
            end else begin
                want     = last_out;
                want.sol = 1'b0;
                want.eol = 1'b0;
                want.eof = 1'b0;
                n_checks++;
                assert (got === want) else begin
                    n_fail++;
                    $error("FAIL hold: observed %h expected %h", got, want);
                end
            end
        end
    end

    task automatic applyStimulus(input logic fs, input logic en, input logic [23:0] d);
        px_t e;
        @(negedge clk);
        bus.frame_start = fs;
        bus.rgb_enable  = en;
        bus.rgb_data_in = d;
        if (fs) begin
            col_m = 0;
            row_m = 0;
        end
        if (en) begin
            e.data = luma(d);
            e.col  = CW'(col_m);
            e.row  = RW'(row_m);
            e.sol  = (col_m == 0);
            e.eol  = (col_m == W - 1);
            e.eof  = (col_m == W - 1) && (row_m == H - 1);
            sb.push_back(e);
            if (col_m == W - 1) begin
                col_m = 0;
                row_m = (row_m == H - 1) ? 0 : row_m + 1;
            end else begin
                col_m++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 24'($urandom));
    endtask

    // Reset is raised between edges so it lands mid-cycle like a real asynchronous event.
    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst_p           = 1'b1;
        bus.rgb_enable  = 1'b0;
        bus.frame_start = 1'b0;
        sb.delete();
        last_out = '0;
        col_m    = 0;
        row_m    = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_p = 1'b0;
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.rgb_enable  = 1'b0;
        bus.rgb_data_in = '0;
        #1;
        rst_p  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_p = 1'b0;
        idle(5);

        applyStimulus(1'b0, 1'b1, 24'hffffff);
        applyStimulus(1'b0, 1'b1, 24'h000000);
        applyStimulus(1'b0, 1'b1, 24'hff0000);
        applyStimulus(1'b0, 1'b1, 24'h00ff00);
        applyStimulus(1'b0, 1'b1, 24'h0000ff);
        applyStimulus(1'b0, 1'b1, 24'h808080);
        idle(4);

        applyStimulus(1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 24'($urandom));
        idle(4);

        applyStimulus(1'b1, 1'b0, 24'h0);
        applyStimulus(1'b0, 1'b1, 24'h102030);
        applyStimulus(1'b0, 1'b0, 24'h405060);
        applyStimulus(1'b0, 1'b0, 24'h708090);
        applyStimulus(1'b0, 1'b1, 24'ha0b0c0);
        idle(4);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 24'($urandom));
        applyStimulus(1'b1, 1'b1, 24'h336699);
        applyStimulus(1'b0, 1'b1, 24'hc0ffee);
        applyStimulus(1'b0, 1'b1, 24'h123456);
        idle(4);

        applyStimulus(1'b0, 1'b1, 24'hffffff);
        applyStimulus(1'b0, 1'b1, 24'h808080);
        do_reset(2);
        idle(3);
        applyStimulus(1'b0, 1'b1, 24'h00ff00);
        idle(5);

        mon_en = 1'b0;
        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
